// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline stall/bubble generation, bypass selects, mult/div busy timer and stall counter
module hazard_stall_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_early_rs,
   input  logic             id_early_rt,
   input  logic             id_is_md,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_wreg,
   input  logic             ex_wen,
   input  logic             ex_is_load,
   input  logic             ex_md_start,
   input  logic             ex_md_op,
   input  logic [4:0]       mem_wreg,
   input  logic             mem_wen,
   input  logic             mem_is_load,
   input  logic [4:0]       wb_wreg,
   input  logic             wb_wen,
   output logic             pc_nen,
   output logic             fd_nen,
   output logic             de_clr,
   output logic [1:0]       fwd_d_rs,
   output logic [1:0]       fwd_d_rt,
   output logic [1:0]       fwd_e_rs,
   output logic [1:0]       fwd_e_rt,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);

   logic [TW-1:0] r_md_cnt;
   logic          w_e_rs, w_e_rt, w_m_rs, w_m_rt;
   logic          w_load_use, w_early_e, w_early_m, w_md, w_stall;

   function automatic logic hit(input logic wen, input logic [4:0] wreg, input logic [4:0] r);
      return wen && (wreg != 5'd0) && (wreg == r);
   endfunction

   // M-stage loads are not yet available, so only ALU/link results bypass from EX/MEM
   function automatic logic [1:0] fsel(input logic [4:0] r);
      return (hit(mem_wen, mem_wreg, r) && !mem_is_load) ? 2'd2 :
             hit(wb_wen, wb_wreg, r)                     ? 2'd1 : 2'd0;
   endfunction

   always_comb begin
      w_e_rs     = hit(ex_wen, ex_wreg, id_rs);
      w_e_rt     = hit(ex_wen, ex_wreg, id_rt);
      w_m_rs     = hit(mem_wen, mem_wreg, id_rs);
      w_m_rt     = hit(mem_wen, mem_wreg, id_rt);
      w_load_use = ex_is_load && ((w_e_rs && id_use_rs) || (w_e_rt && id_use_rt));
      w_early_e  = (w_e_rs && id_early_rs) || (w_e_rt && id_early_rt);
      w_early_m  = mem_is_load && ((w_m_rs && id_early_rs) || (w_m_rt && id_early_rt));
      w_md       = id_is_md && (md_busy || ex_md_start);
      w_stall    = !reset && (w_load_use || w_early_e || w_early_m || w_md);
      pc_nen     = w_stall;
      fd_nen     = w_stall;
      de_clr     = w_stall;
      fwd_d_rs   = fsel(id_rs);
      fwd_d_rt   = fsel(id_rt);
      fwd_e_rs   = fsel(ex_rs);
      fwd_e_rt   = fsel(ex_rt);
   end

   assign md_busy = (r_md_cnt != '0);

   // a start while busy is a protocol violation and is deliberately ignored
   always_ff @(posedge clk) begin
      if (reset)
         r_md_cnt <= '0;
      else if (ex_md_start && !md_busy)
         r_md_cnt <= ex_md_op ? TW'(DIV_CYCLES) : TW'(MULT_CYCLES);
      else if (md_busy)
         r_md_cnt <= r_md_cnt - TW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (w_stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed test-plan sequences plus random traffic against a cycle-indexed reference model
module tb_hazard_stall_ctrl;
   localparam int MC = 5;
   localparam int DC = 10;

   logic       clk = 0;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
   logic       id_use_rs, id_use_rt, id_early_rs, id_early_rt, id_is_md;
   logic       ex_wen, ex_is_load, ex_md_start, ex_md_op, mem_wen, mem_is_load, wb_wen;
   logic       pc_nen, fd_nen, de_clr, md_busy;
   logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
   logic [31:0] stall_cnt;
   logic       pc4, fd4, de4, busy4;
   logic [1:0] fdrs4, fdrt4, fers4, fert4;
   logic [3:0] cnt4;

   int     n_chk = 0, n_err = 0;
   longint cyc = 0, busy_end = -1, mcnt = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_early_rs(id_early_rs), .id_early_rt(id_early_rt), .id_is_md(id_is_md), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wreg(ex_wreg), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_md_start(ex_md_start), .ex_md_op(ex_md_op),
      .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_wreg(wb_wreg), .wb_wen(wb_wen),
      .pc_nen(pc_nen), .fd_nen(fd_nen), .de_clr(de_clr), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
      .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy), .stall_cnt(stall_cnt));

   hazard_stall_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC), .CNT_W(4)) u_dut4 (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_early_rs(id_early_rs), .id_early_rt(id_early_rt), .id_is_md(id_is_md), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ex_wreg(ex_wreg), .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_md_start(ex_md_start), .ex_md_op(ex_md_op),
      .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_is_load(mem_is_load), .wb_wreg(wb_wreg), .wb_wen(wb_wen),
      .pc_nen(pc4), .fd_nen(fd4), .de_clr(de4), .fwd_d_rs(fdrs4), .fwd_d_rt(fdrt4),
      .fwd_e_rs(fers4), .fwd_e_rt(fert4), .md_busy(busy4), .stall_cnt(cnt4));

   task automatic check(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit wr(input logic wen, input logic [4:0] wreg, input logic [4:0] r);
      return wen && wreg != 0 && wreg == r;
   endfunction

   function automatic longint ref_fwd(input logic [4:0] r);
      if (wr(mem_wen, mem_wreg, r) && !mem_is_load) return 2;
      if (wr(wb_wen, wb_wreg, r)) return 1;
      return 0;
   endfunction

   function automatic bit ref_stall(input bit busy);
      bit lu, ee, em, md;
      lu = ex_is_load && ((id_use_rs && wr(ex_wen, ex_wreg, id_rs)) || (id_use_rt && wr(ex_wen, ex_wreg, id_rt)));
      ee = (id_early_rs && wr(ex_wen, ex_wreg, id_rs)) || (id_early_rt && wr(ex_wen, ex_wreg, id_rt));
      em = mem_is_load && ((id_early_rs && wr(mem_wen, mem_wreg, id_rs)) || (id_early_rt && wr(mem_wen, mem_wreg, id_rt)));
      md = id_is_md && (busy || ex_md_start);
      return !reset && (lu || ee || em || md);
   endfunction

   function automatic longint sat(input int w);
      longint top = (longint'(1) << w) - 1;
      return (mcnt > top) ? top : mcnt;
   endfunction

   task automatic cycle();
      bit busy, st;
      @(negedge clk);
      busy = (cyc <= busy_end);
      st = ref_stall(busy);
      check("md_busy", md_busy, busy);
      check("pc_nen", pc_nen, st);
      check("fd_nen", fd_nen, st);
      check("de_clr", de_clr, st);
      check("fwd_d_rs", fwd_d_rs, ref_fwd(id_rs));
      check("fwd_d_rt", fwd_d_rt, ref_fwd(id_rt));
      check("fwd_e_rs", fwd_e_rs, ref_fwd(ex_rs));
      check("fwd_e_rt", fwd_e_rt, ref_fwd(ex_rt));
      check("stall_cnt", stall_cnt, sat(32));
      check("stall_cnt4", cnt4, sat(4));
      check("md_busy4", busy4, busy);
      check("pc_nen4", pc4, st);
      if (reset) begin
         mcnt = 0;
         busy_end = cyc;
      end else begin
         if (st) mcnt++;
         if (ex_md_start && !busy) busy_end = cyc + (ex_md_op ? DC : MC);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      {id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg} = '0;
      {id_use_rs, id_use_rt, id_early_rs, id_early_rt, id_is_md} = '0;
      {ex_wen, ex_is_load, ex_md_start, ex_md_op, mem_wen, mem_is_load, wb_wen} = '0;
   endtask

   task automatic do_reset();
      clr_in();
      reset = 1;
      ex_is_load = 1; ex_wen = 1; ex_wreg = 8; id_rs = 8; id_use_rs = 1;
      cycle();
      reset = 0;
      clr_in();
   endtask

   function automatic bit mbusy();
      return cyc <= busy_end;
   endfunction

   initial begin
      clr_in();
      reset = 1;
      @(posedge clk);
      #1;
      do_reset();
      check("rst_cnt", stall_cnt, 0);
      check("rst_busy", md_busy, 0);

      ex_is_load = 1; ex_wen = 1; ex_wreg = 8; id_rs = 8; id_use_rs = 1;
      cycle();
      check("lu_cnt", stall_cnt, 1);
      ex_wreg = 0;
      cycle();
      check("lu_r0_cnt", stall_cnt, 1);
      clr_in();

      id_early_rt = 1; id_rt = 9; ex_wen = 1; ex_wreg = 9;
      cycle();
      ex_wen = 0; mem_wen = 1; mem_wreg = 9;
      #1 check("br_fwd_d_rt", fwd_d_rt, 2);
      cycle();
      mem_is_load = 1;
      cycle();
      check("br_cnt", stall_cnt, 3);
      clr_in();

      ex_rs = 5; mem_wen = 1; mem_wreg = 5; wb_wen = 1; wb_wreg = 5;
      #1 check("prio_m", fwd_e_rs, 2);
      cycle();
      mem_wen = 0;
      #1 check("prio_w", fwd_e_rs, 1);
      cycle();
      mem_wen = 1; mem_is_load = 1; wb_wen = 0;
      #1 check("prio_ld", fwd_e_rs, 0);
      cycle();
      clr_in();

      do_reset();
      ex_md_start = 1; ex_md_op = 1; id_is_md = 1;
      cycle();
      ex_md_start = 0;
      repeat (DC) cycle();
      check("div_cnt", stall_cnt, DC + 1);
      check("div_done", md_busy, 0);
      cycle();
      check("div_release", stall_cnt, DC + 1);
      clr_in();

      do_reset();
      ex_md_start = 1; ex_md_op = 0;
      cycle();
      ex_md_start = 0; id_is_md = 1;
      cycle();
      reset = 1;
      cycle();
      reset = 0;
      check("rst_mid_busy", md_busy, 0);
      check("rst_mid_cnt", stall_cnt, 0);
      cycle();
      clr_in();

      do_reset();
      ex_is_load = 1; ex_wen = 1; ex_wreg = 8; id_rs = 8; id_use_rs = 1;
      repeat (20) cycle();
      check("sat4", cnt4, 15);
      check("nosat32", stall_cnt, 20);
      clr_in();

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         id_rs       = 5'($urandom_range(0, 3));
         id_rt       = 5'($urandom_range(0, 3));
         ex_rs       = 5'($urandom_range(0, 3));
         ex_rt       = 5'($urandom_range(0, 3));
         ex_wreg     = 5'($urandom_range(0, 3));
         mem_wreg    = 5'($urandom_range(0, 3));
         wb_wreg     = 5'($urandom_range(0, 3));
         {id_use_rs, id_use_rt, id_early_rs, id_early_rt} = 4'($urandom);
         id_is_md    = ($urandom_range(0, 3) == 0);
         {ex_wen, ex_is_load, mem_wen, mem_is_load, wb_wen, ex_md_op} = 6'($urandom);
         ex_md_start = !mbusy() && ($urandom_range(0, 7) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
